// File: rtl/mod_seq_unit.sv
// rtl/mod_seq_unit.sv - sequential unsigned a mod b by repeated subtraction, start/done handshake
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, sampled only in IDLE
//   a, b      dividend / divisor, captured on the accepting edge
//   busy      high while in CHECK
//   done      one-cycle pulse in DONE
//   result    registered remainder, held until the next DONE
//   div_zero  captured divisor was zero; valid with done, held like result

module mod_seq_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] rem_q, rem_nx;
    logic [WIDTH-1:0] dvs_q, dvs_nx;
    logic [WIDTH-1:0] result_nx;
    logic             div_zero_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvs_q    <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            state_q  <= state_nx;
            rem_q    <= rem_nx;
            dvs_q    <= dvs_nx;
            result   <= result_nx;
            div_zero <= div_zero_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        rem_nx      = rem_q;
        dvs_nx      = dvs_q;
        result_nx   = result;
        div_zero_nx = div_zero;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_nx      = a;
                    dvs_nx      = b;
                    // result keeps the previous remainder through CHECK
                    div_zero_nx = 1'b0;
                    state_nx    = CHECK;
                end
            end

            CHECK: begin
                busy = 1'b1;
                if (dvs_q == '0) begin
                    result_nx   = rem_q;
                    div_zero_nx = 1'b1;
                    state_nx    = DONE;
                end else if (rem_q < dvs_q) begin
                    result_nx = rem_q;
                    state_nx  = DONE;
                end else begin
                    // rem_q >= dvs_q here, so the subtraction cannot borrow
                    rem_nx = rem_q - dvs_q;
                end
            end

            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_seq_unit.sv
// tb/tb_mod_seq_unit.sv - self-checking bench for mod_seq_unit

module tb_mod_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       div_zero;

    int errors = 0;
    int checks = 0;
    int exp_prev = 0;

    mod_seq_unit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_result;
        logic       exp_dz;
        int         exp_done_cycle;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at a sample point in IDLE (cycle 0). Returns at the sample point
    // of the done cycle, or after a 40-cycle bound.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input int exp_dc,
                          input logic [3:0] er, input logic edz, input bit hold);
        int dc;
        int busy_bad;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        step();
        if (hold) begin
            a = 4'd1;
        end else begin
            start = 1'b0;
            a     = 4'($urandom);
            b     = 4'($urandom);
        end
        chk("div_zero_cleared_at_accept", int'(div_zero), 0);
        chk("result_held_during_check", int'(result), exp_prev);
        dc       = 0;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                dc = k;
                break;
            end
            if (!busy) busy_bad++;
            if (!hold) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            step();
        end
        chk("done_cycle", dc, exp_dc);
        chk("busy_cycles_before_done", busy_bad, 0);
        chk("busy_low_at_done", int'(busy), 0);
        chk("result", int'(result), int'(er));
        chk("div_zero", int'(div_zero), int'(edz));
        exp_prev = int'(er);
    endtask

    initial begin
        int saw_done;

        vecs[0] = '{a: 4'd13, b: 4'd4, exp_result: 4'd1, exp_dz: 1'b0, exp_done_cycle: 5};
        vecs[1] = '{a: 4'd3,  b: 4'd7, exp_result: 4'd3, exp_dz: 1'b0, exp_done_cycle: 2};
        vecs[2] = '{a: 4'd15, b: 4'd1, exp_result: 4'd0, exp_dz: 1'b0, exp_done_cycle: 17};
        vecs[3] = '{a: 4'd0,  b: 4'd5, exp_result: 4'd0, exp_dz: 1'b0, exp_done_cycle: 2};
        vecs[4] = '{a: 4'd9,  b: 4'd0, exp_result: 4'd9, exp_dz: 1'b1, exp_done_cycle: 2};
        vecs[5] = '{a: 4'd8,  b: 4'd3, exp_result: 4'd2, exp_dz: 1'b0, exp_done_cycle: 4};

        // Reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd2;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_busy", int'(busy), 0);
            chk("reset_done", int'(done), 0);
            chk("reset_result", int'(result), 0);
            chk("reset_div_zero", int'(div_zero), 0);
        end
        // Release: the first IDLE edge must accept (5 mod 2, q=2)
        rst_n = 1'b1;
        run_op(4'd5, 4'd2, 4, 4'd1, 1'b0, 1'b0);
        step();
        chk("idle_after_done_busy", int'(busy), 0);
        chk("idle_after_done_done", int'(done), 0);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_done_cycle,
                   vecs[i].exp_result, vecs[i].exp_dz, 1'b0);
            step();
            chk("held_result_in_idle", int'(result), int'(vecs[i].exp_result));
            chk("held_div_zero_in_idle", int'(div_zero), int'(vecs[i].exp_dz));
            chk("no_done_in_idle", int'(done), 0);
        end

        // Start held high with a changed during CHECK: no restart, result 14 mod 3 = 2
        b = 4'd3;
        run_op(4'd14, 4'd3, 6, 4'd2, 1'b0, 1'b1);
        // start still high through DONE; only the IDLE edge accepts (a=1, b=3)
        step();
        chk("hold_idle_busy", int'(busy), 0);
        chk("hold_idle_done", int'(done), 0);
        chk("hold_idle_result", int'(result), 2);
        step();
        chk("reaccept_busy", int'(busy), 1);
        start = 1'b0;
        step();
        chk("reaccept_done", int'(done), 1);
        chk("reaccept_result", int'(result), 1);
        step();

        // Abort: 15 mod 1 started, reset asserted in cycle 6
        start    = 1'b1;
        a        = 4'd15;
        b        = 4'd1;
        saw_done = 0;
        step();
        start = 1'b0;
        for (int k = 1; k < 6; k++) begin
            if (done) saw_done++;
            step();
        end
        chk("abort_busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done) saw_done++;
            step();
        end
        chk("abort_no_done", saw_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
